// File: rtl/cybernid_input_quantizer_if.sv
// Stream bundle between the raw-feature source, the quantizer and layer 0:
// raw feature beats in (s_*), packed code vectors out (m_*).
interface cybernid_input_quantizer_if #(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned IN_WIDTH     = 8
);
  logic                      s_valid;
  logic                      s_ready;
  logic [IN_WIDTH-1:0]       s_data;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [2*NUM_FEATURES-1:0] m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/cybernid_input_quantizer.sv
// Thresholds raw feature words to 2-bit codes and packs one frame of codes
// into a registered vector for the layer-0 neuron array.
module cybernid_input_quantizer #(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned THRESH0      = 64,
  parameter int unsigned THRESH1      = 128,
  parameter int unsigned THRESH2      = 192
) (
  input  logic                        clk,
  input  logic                        rst,
  cybernid_input_quantizer_if.slave   bus,
  output logic                        frame_err
);

  localparam int unsigned VEC_W = 2 * NUM_FEATURES;
  localparam int unsigned CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_FEATURES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] asm_q, asm_d;
  logic [VEC_W-1:0] m_data_q, m_data_d;
  logic             asm_full_q, asm_full_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             frame_err_q, frame_err_d;

  logic [1:0] code_c;
  logic       accept_c;
  logic       last_slot_c;
  logic       err_c;
  logic       done_c;
  logic       consume_c;
  logic       out_free_c;

  // Unsigned threshold compare at full input width
  always_comb begin
    code_c = 2'd3;
    if (bus.s_data < IN_WIDTH'(THRESH0)) begin
      code_c = 2'd0;
    end else if (bus.s_data < IN_WIDTH'(THRESH1)) begin
      code_c = 2'd1;
    end else if (bus.s_data < IN_WIDTH'(THRESH2)) begin
      code_c = 2'd2;
    end
  end

  assign accept_c    = bus.s_valid && s_ready_q;
  assign last_slot_c = (cnt_q == LAST_SLOT);
  assign err_c       = accept_c && (bus.s_last != last_slot_c);
  assign done_c      = accept_c && bus.s_last && last_slot_c;
  assign consume_c   = m_valid_q && bus.m_ready;
  assign out_free_c  = !m_valid_q || bus.m_ready;

  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;

    // Erroneous beats also land in the buffer; the stale slots are simply
    // overwritten by the next frame before it can complete.
    if (accept_c) begin
      asm_d[{cnt_q, 1'b0} +: 2] = code_c;
      cnt_d = (err_c || done_c) ? '0 : cnt_q + CNT_W'(1);
    end

    if (consume_c) begin
      m_valid_d = 1'b0;
    end

    // A held frame refills the output on the same edge it drains
    if (asm_full_q && consume_c) begin
      m_data_d   = asm_q;
      m_valid_d  = 1'b1;
      asm_full_d = 1'b0;
    end

    if (done_c) begin
      if (out_free_c) begin
        m_data_d  = asm_d;
        m_valid_d = 1'b1;
      end else begin
        asm_full_d = 1'b1;
      end
    end

    s_ready_d   = !asm_full_d;
    frame_err_d = err_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      s_ready_q   <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      s_ready_q   <= s_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign frame_err   = frame_err_q;

endmodule
